multicycle_control_unit: RTL
============================

# multicycle_control_unit

Parametrised multicycle MIPS control unit. It succeeds the fixed three-instruction controller. It adds:
- configurable memory wait states with an internal wait counter;
- R-type add/sub/and/xor/slt, lw, sw, beq, bne and j;
- an illegal-instruction flag.

It sits between the instruction register (opcode/funct fields) and the datapath mux/enable controls.

## Interface
- MEM_WAIT, 2, memory read/write latency in cycles, legal range 1..15
- OPCODE_W, 6, opcode field width
- FUNCT_W, 6, funct field width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  OPCODE_W  IR[31:26], stable from DECODE until return to FETCH_WAIT
- funct  in  FUNCT_W  IR[5:0], same stability
- PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite, AluSrcA, RegWrite, RegDst, AWrite, BWrite, AluOutWrite  out  1 each  datapath controls
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- AluSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOpOut  out  3  LOAD=0, ADD=1, SUB=2, AND=3, INC=4, NEG=5, XOR=6, COMP=7
- State_out  out  6  current state encoding, for debug
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct

## Operation
- Moore outputs decode from state only; ALUOpOut in R_EXEC also decodes from funct. Every control not listed for a state drives 0; no X values.
- FETCH_WAIT: MemRead=1, IorD=0. Stay while wait_cnt < MEM_WAIT-1, then go to FETCH_IR.
- FETCH_IR: MemRead=1, IorD=0, IRWrite=1, PCWrite=1, AluSrcA=0, AluSrcB=01, ALUOp=ADD, PCSource=00. Go to DECODE.
- DECODE: AWrite=BWrite=AluOutWrite=1, AluSrcA=0, AluSrcB=11, ALUOp=ADD (branch target). Dispatch:
  - opcode 0x00 with funct 0x20/0x22/0x24/0x26/0x2A -> R_EXEC
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x04 or 0x05 -> BRANCH
  - 0x02 -> JUMP
  - anything else -> ILLEGAL
- R_EXEC: AluSrcA=1, AluSrcB=00, AluOutWrite=1. ALUOp maps funct 0x20->ADD, 0x22->SUB, 0x24->AND, 0x26->XOR, 0x2A->COMP. Go to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH_WAIT.
- MEM_ADDR: AluSrcA=1, AluSrcB=10, ALUOp=ADD, AluOutWrite=1. Go to MEM_RD_WAIT for 0x23, MEM_WR for 0x2B.
- MEM_RD_WAIT: MemRead=1, IorD=1. Held MEM_WAIT cycles, then go to MEM_RD_WB.
- MEM_RD_WB: RegWrite=1, RegDst=0, MemtoReg=1. Go to FETCH_WAIT.
- MEM_WR: MemWrite=1, IorD=1. Held MEM_WAIT cycles, then go to FETCH_WAIT.
- BRANCH: AluSrcA=1, AluSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01, BranchNe=(opcode==0x05). Go to FETCH_WAIT.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH_WAIT.
- ILLEGAL: illegal=1 for one cycle. Go to FETCH_WAIT; PC already advanced.
- wait_cnt: width $clog2(MEM_WAIT+1).
  - Clears to 0 on every transition into FETCH_WAIT, MEM_RD_WAIT or MEM_WR.
  - Increments each cycle spent in those states.
  - Never wraps: the exit compare fires at MEM_WAIT-1.

## Timing
- Reset asserted: state=FETCH_WAIT and wait_cnt=0 immediately (asynchronous).
  - Outputs are then MemRead=1, IorD=0, all others 0, ALUOpOut=LOAD, State_out=FETCH_WAIT code.
- Reset mid-operation: MemWrite/RegWrite/PCWrite drop in the same cycle. No partial instruction completes.
- First rising edge after reset deassertion counts as wait cycle 1.
- Latency in cycles, first FETCH_WAIT to last state inclusive:
  - R-type: MEM_WAIT+4
  - lw: 2*MEM_WAIT+4
  - sw: 2*MEM_WAIT+3
  - beq/bne, j, illegal: MEM_WAIT+3
- MEM_WAIT=1: each wait state lasts exactly one cycle.
- Back-to-back instructions: no idle cycle between the last state and FETCH_WAIT.

## Structure
- Package control_pkg holds:
  - alu_op_t enum (8 ops, encoding above)
  - state_t enum, 6-bit
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J
  - funct constants F_ADD, F_SUB, F_AND, F_XOR, F_SLT
- One sub-module, ctrl_wait_counter: parameter MEM_WAIT; inputs clear/enable; output done. Reset 0.
- Top contains the state register, next-state logic and output decode.

## Test plan
- MEM_WAIT=2, add (op 0, funct 0x20): 6 cycles. R_EXEC shows ALUOp=ADD, R_WB shows RegWrite=1, RegDst=1, then FETCH_WAIT.
- MEM_WAIT=3, lw (0x23): MemRead/IorD=1 held exactly 3 cycles in MEM_RD_WAIT. MEM_RD_WB has MemtoReg=1. Total 10 cycles.
- MEM_WAIT=1, sw then bne (0x05): MemWrite high exactly 1 cycle. BRANCH shows PCWriteCond=1, BranchNe=1, ALUOp=SUB, PCSource=01.
- j (0x02): JUMP shows PCWrite=1, PCSource=10. Next cycle is FETCH_WAIT with wait_cnt=0.
- Op 0x3F, and op 0 with funct 0x00: illegal pulses exactly 1 cycle, RegWrite and MemWrite never asserted, fetch resumes.
- Reset asserted mid-MEM_WR (MEM_WAIT=4, cycle 2): MemWrite falls in the same cycle, state=FETCH_WAIT. After release the full fetch takes 4 cycles.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and instruction-field constants for the multicycle MIPS control unit.
package control_pkg;

    typedef enum logic [2:0] {
        ALU_LOAD = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_INC  = 3'd4,
        ALU_NEG  = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_COMP = 3'd7
    } alu_op_t;

    typedef enum logic [5:0] {
        S_FETCH_WAIT  = 6'd0,
        S_FETCH_IR    = 6'd1,
        S_DECODE      = 6'd2,
        S_R_EXEC      = 6'd3,
        S_R_WB        = 6'd4,
        S_MEM_ADDR    = 6'd5,
        S_MEM_RD_WAIT = 6'd6,
        S_MEM_RD_WB   = 6'd7,
        S_MEM_WR      = 6'd8,
        S_BRANCH      = 6'd9,
        S_JUMP        = 6'd10,
        S_ILLEGAL     = 6'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_SLT = 6'h2A;

endpackage

// File: rtl/ctrl_wait_counter.sv
// Memory wait-state counter: counts cycles spent in a wait state, done at MEM_WAIT-1.
module ctrl_wait_counter #(
    parameter int MEM_WAIT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CW = $clog2(MEM_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at LAST so a held enable can never wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: state register, dispatch logic and Moore datapath controls.
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                BranchNe,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                IRWrite,
    output logic                AluSrcA,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                AWrite,
    output logic                BWrite,
    output logic                AluOutWrite,
    output logic [1:0]          PCSource,
    output logic [1:0]          AluSrcB,
    output logic [2:0]          ALUOpOut,
    output logic [5:0]          State_out,
    output logic                illegal
);

    localparam logic [OPCODE_W-1:0] OPC_RTYPE = OPCODE_W'(OP_RTYPE);
    localparam logic [OPCODE_W-1:0] OPC_LW    = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] OPC_SW    = OPCODE_W'(OP_SW);
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] OPC_BNE   = OPCODE_W'(OP_BNE);
    localparam logic [OPCODE_W-1:0] OPC_J     = OPCODE_W'(OP_J);

    state_t  state_q, state_d;
    alu_op_t r_alu;
    alu_op_t alu_op;
    logic    funct_ok;
    logic    in_wait;
    logic    wait_en;
    logic    wait_done;

    always_comb begin
        r_alu = ALU_LOAD;
        case (funct)
            FUNCT_W'(F_ADD): r_alu = ALU_ADD;
            FUNCT_W'(F_SUB): r_alu = ALU_SUB;
            FUNCT_W'(F_AND): r_alu = ALU_AND;
            FUNCT_W'(F_XOR): r_alu = ALU_XOR;
            FUNCT_W'(F_SLT): r_alu = ALU_COMP;
            default:         r_alu = ALU_LOAD;
        endcase
    end

    assign funct_ok = (r_alu != ALU_LOAD);

    // Counter runs only while parked in a wait state; any other cycle clears it,
    // so every entry into a wait state starts from zero.
    assign in_wait = (state_q == S_FETCH_WAIT) || (state_q == S_MEM_RD_WAIT) ||
                     (state_q == S_MEM_WR);
    assign wait_en = in_wait && !wait_done;

    ctrl_wait_counter #(
        .MEM_WAIT(MEM_WAIT)
    ) u_wait (
        .clock (clock),
        .reset (reset),
        .clear (!wait_en),
        .enable(wait_en),
        .done  (wait_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH_WAIT:  if (wait_done) state_d = S_FETCH_IR;
            S_FETCH_IR:    state_d = S_DECODE;
            S_DECODE: begin
                if ((opcode == OPC_RTYPE) && funct_ok)          state_d = S_R_EXEC;
                else if ((opcode == OPC_LW) || (opcode == OPC_SW))   state_d = S_MEM_ADDR;
                else if ((opcode == OPC_BEQ) || (opcode == OPC_BNE)) state_d = S_BRANCH;
                else if (opcode == OPC_J)                       state_d = S_JUMP;
                else                                            state_d = S_ILLEGAL;
            end
            S_R_EXEC:      state_d = S_R_WB;
            S_MEM_ADDR:    state_d = (opcode == OPC_LW) ? S_MEM_RD_WAIT : S_MEM_WR;
            S_MEM_RD_WAIT: if (wait_done) state_d = S_MEM_RD_WB;
            S_MEM_WR:      if (wait_done) state_d = S_FETCH_WAIT;
            default:       state_d = S_FETCH_WAIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        AluSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        AWrite      = 1'b0;
        BWrite      = 1'b0;
        AluOutWrite = 1'b0;
        PCSource    = 2'b00;
        AluSrcB     = 2'b00;
        alu_op      = ALU_LOAD;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH_WAIT: begin
                MemRead = 1'b1;
            end
            S_FETCH_IR: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                AluSrcB = 2'b01;
                alu_op  = ALU_ADD;
            end
            S_DECODE: begin
                AWrite      = 1'b1;
                BWrite      = 1'b1;
                AluOutWrite = 1'b1;
                AluSrcB     = 2'b11;
                alu_op      = ALU_ADD;
            end
            S_R_EXEC: begin
                AluSrcA     = 1'b1;
                AluOutWrite = 1'b1;
                alu_op      = r_alu;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_MEM_ADDR: begin
                AluSrcA     = 1'b1;
                AluSrcB     = 2'b10;
                AluOutWrite = 1'b1;
                alu_op      = ALU_ADD;
            end
            S_MEM_RD_WAIT: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_RD_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_BRANCH: begin
                AluSrcA     = 1'b1;
                alu_op      = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = (opcode == OPC_BNE);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    assign ALUOpOut  = alu_op;
    assign State_out = state_q;

endmodule
